// File: rtl/seq_divider.sv
`timescale 1ns/1ps
// Sequential 32-bit divider: radix-2 restoring, one quotient bit per cycle.
// Handles MIPS DIV (signed) and DIVU (unsigned), with a divide-by-zero flag.
module seq_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        dz_q;

  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // 32'h80000000 negates to itself, which is its correct 2^31 magnitude.
  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
    if (is_signed && dividend[31]) dividend_mag = ~dividend + 32'd1;
    if (is_signed && divisor[31])  divisor_mag  = ~divisor + 32'd1;
  end

  always_comb begin
    shifted  = {rem_q, quo_q[31]};
    diff     = shifted - {1'b0, dvs_q};
    rem_step = shifted[31:0];
    quo_step = {quo_q[30:0], 1'b0};
    if (!diff[32]) begin
      rem_step = diff[31:0];
      quo_step = {quo_q[30:0], 1'b1};
    end
  end

  // A zero divisor leaves the dividend magnitude in rem_q, so sign
  // correction alone restores the original dividend.
  always_comb begin
    quo_fix = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
    if (dz_q) quo_fix = 32'hFFFF_FFFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 6'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      dvs_q       <= 32'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            state_q   <= StRun;
            cnt_q     <= 6'd0;
            rem_q     <= 32'd0;
            quo_q     <= dividend_mag;
            dvs_q     <= divisor_mag;
            neg_quo_q <= is_signed & (dividend[31] ^ divisor[31]);
            neg_rem_q <= is_signed & dividend[31];
            dz_q      <= (divisor == 32'd0);
            busy      <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        StRun: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= StFix;
        end
        StFix: begin
          quotient    <= quo_fix;
          remainder   <= rem_fix;
          div_by_zero <= dz_q;
          busy        <= 1'b0;
          done        <= 1'b1;
          state_q     <= StDone;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have the port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port `start`, input, 1 bit: request a division; it SHALL be sampled only when the block is not busy.
REQ-004 The block SHALL have the port `is_signed`, input, 1 bit: 1 selects two's-complement division (MIPS DIV), 0 selects unsigned division (DIVU); it SHALL be sampled with `start`.
REQ-005 The block SHALL have the port `dividend`, input, 32 bits: the numerator, sampled with `start`.
REQ-006 The block SHALL have the port `divisor`, input, 32 bits: the denominator, sampled with `start`.
REQ-007 The block SHALL have the port `busy`, output, 1 bit: high while a division is in progress.
REQ-008 The block SHALL have the port `done`, output, 1 bit: a single-cycle pulse indicating that the results are valid.
REQ-009 The block SHALL have the port `quotient`, output, 32 bits: the result for LO.
REQ-010 The block SHALL have the port `remainder`, output, 32 bits: the result for HI.
REQ-011 The block SHALL have the port `div_by_zero`, output, 1 bit: high with `done` when the captured divisor was 0.

Function
REQ-012 The block SHALL implement the states IDLE, RUN, FIX and DONE; only one state SHALL be active at a time.
REQ-013 In IDLE or DONE, `start`=1 at edge k SHALL capture the operands and `is_signed`, clear the iteration counter, and enter RUN.
REQ-014 In signed mode, operands SHALL be converted to magnitudes at capture, and the quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign) SHALL be stored.
REQ-015 RUN SHALL perform one radix-2 restoring step per cycle:
- shift {remainder, quotient} left by 1;
- trial-subtract the divisor magnitude using a 33-bit difference;
- if the difference is non-negative, keep it and set the quotient LSB to 1.
REQ-016 RUN SHALL last exactly 32 cycles, counted by a 6-bit counter, then enter FIX.
REQ-017 FIX SHALL apply the sign corrections by two's-complement negation, register `quotient`, `remainder` and `div_by_zero`, and enter DONE.
REQ-018 `done` SHALL be 1 for exactly the one cycle spent in DONE, i.e. high after edge k+33 and low after edge k+34 unless a new start is accepted.
REQ-019 `busy` SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-020 Without a new `start`, DONE SHALL return to IDLE after one cycle.
REQ-021 `start` asserted while `busy`=1 SHALL be ignored, with no effect on the operation in progress or on its result.
REQ-022 `start` asserted in the DONE cycle SHALL be accepted, which permits back-to-back operation every 34 cycles.
REQ-023 `quotient`, `remainder` and `div_by_zero` SHALL hold their values from FIX until the next FIX.
REQ-024 Division results SHALL truncate toward zero, and a nonzero remainder SHALL carry the sign of the dividend.
REQ-025 If the divisor is 0, in either mode:
- `quotient` SHALL be 32'hFFFFFFFF;
- `remainder` SHALL be the original dividend;
- `div_by_zero` SHALL be 1;
- latency SHALL be unchanged.
REQ-026 Signed overflow (32'h80000000 / 32'hFFFFFFFF) SHALL yield `quotient`=32'h80000000, `remainder`=0 and `div_by_zero`=0.
REQ-027 A signed dividend or divisor of 32'h80000000 SHALL use its magnitude 2^31 as an unsigned value, with no saturation.

Reset
REQ-028 `rst`=1 at a rising edge SHALL force the following, regardless of state:
- state IDLE and counter 0;
- `busy`=0 and `done`=0;
- `quotient`=0, `remainder`=0, `div_by_zero`=0.
REQ-029 Reset SHALL have priority over `start`.
REQ-030 Reset during RUN or FIX SHALL abort the operation, and no `done` pulse SHALL follow it.

Verification
REQ-031 The bench SHALL apply unsigned 100 / 7 with start at edge k and check `busy`=1 from k+1 to k+32, `done`=1 only after k+33, `quotient`=14 and `remainder`=2.
REQ-032 The bench SHALL apply signed 32'hFFFFFFF9 / 2 (-7/2) and check `quotient`=32'hFFFFFFFD and `remainder`=32'hFFFFFFFF; it SHALL also apply signed 7 / 32'hFFFFFFFE and check `quotient`=32'hFFFFFFFD and `remainder`=1.
REQ-033 The bench SHALL apply signed 32'h80000000 / 32'hFFFFFFFF and check `quotient`=32'h80000000, `remainder`=0 and `div_by_zero`=0; it SHALL also apply unsigned 32'hFFFFFFFF / 1 and check `quotient`=32'hFFFFFFFF and `remainder`=0.
REQ-034 The bench SHALL apply a divisor of 0 with dividend 32'h12345678 in both modes and check `quotient`=32'hFFFFFFFF, `remainder`=32'h12345678, `div_by_zero`=1 and `done` after 33 edges.
REQ-035 The bench SHALL pulse `start` with new operands (50 / 5) at RUN cycle 5, and check the original result is unaffected; it SHALL then start 50 / 5 in the DONE cycle, and check `done` exactly 34 cycles after the previous `done` with `quotient`=10.
REQ-036 The bench SHALL assert `rst` at RUN cycle 10, and check on the next cycle that `busy`=0, all outputs are 0, and no `done` appears within 40 cycles.
